// File: rtl/stdp_pkg.sv
// stdp_pkg: shared STDP defaults plus timer, decayed-step and clamp helpers.
package stdp_pkg;
  localparam int NUM_PRE_DEF     = 4;
  localparam int WEIGHT_W_DEF    = 8;
  localparam int TIMER_W_DEF     = 6;
  localparam int WINDOW_DEF      = 16;
  localparam int A_PLUS_DEF      = 16;
  localparam int A_MINUS_DEF     = 12;
  localparam int DECAY_SHIFT_DEF = 2;
  localparam int W_INIT_DEF      = 64;
  function automatic int timer_next(input logic spike, input int q, input int tmax);
    return spike ? 0 : (q < tmax ? q + 1 : tmax);
  endfunction
  function automatic int decayed_step(input int base, input int dt, input int shift);
    return base >> (dt >> shift);
  endfunction
  function automatic int clamp_hi(input int v, input int hi);
    return v > hi ? hi : v;
  endfunction
  function automatic int clamp_lo(input int v);
    return v < 0 ? 0 : v;
  endfunction
endpackage

// File: rtl/stdp_syn_channel.sv
// stdp_syn_channel: one presynaptic timer, its weight register and the LTP/LTD datapath.
module stdp_syn_channel
  import stdp_pkg::*;
#(
  parameter int WEIGHT_W    = WEIGHT_W_DEF,
  parameter int TIMER_W     = TIMER_W_DEF,
  parameter int WINDOW      = WINDOW_DEF,
  parameter int A_PLUS      = A_PLUS_DEF,
  parameter int A_MINUS     = A_MINUS_DEF,
  parameter int DECAY_SHIFT = DECAY_SHIFT_DEF,
  parameter int W_INIT      = W_INIT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                learn_en_i,
  input  logic                pre_spike_i,
  input  logic                post_spike_i,
  input  logic                post_valid_i,
  input  logic [TIMER_W-1:0]  post_timer_i,
  input  logic                load_i,
  input  logic [WEIGHT_W-1:0] load_data_i,
  output logic [TIMER_W-1:0]  timer_o,
  output logic [WEIGHT_W-1:0] weight_o,
  output logic                changed_o
);
  localparam int WMAX = 2**WEIGHT_W - 1;
  localparam int TMAX = 2**TIMER_W - 1;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic valid_q;
  logic [WEIGHT_W-1:0] w_q, w_d, stdp_w;
  logic ltp, ltd;
  int up, dn;
  // ltp and ltd are mutually exclusive: one needs pre_spike low, the other high
  always_comb begin
    timer_d   = TIMER_W'(timer_next(pre_spike_i, int'(timer_q), TMAX));
    ltp       = learn_en_i && post_spike_i && valid_q && !pre_spike_i && int'(timer_q) < WINDOW;
    ltd       = learn_en_i && pre_spike_i && post_valid_i && !post_spike_i && int'(post_timer_i) < WINDOW;
    up        = clamp_hi(int'(w_q) + decayed_step(A_PLUS, int'(timer_q), DECAY_SHIFT), WMAX);
    dn        = clamp_lo(int'(w_q) - decayed_step(A_MINUS, int'(post_timer_i), DECAY_SHIFT));
    stdp_w    = ltp ? WEIGHT_W'(up) : ltd ? WEIGHT_W'(dn) : w_q;
    w_d       = load_i ? load_data_i : stdp_w;
    changed_o = !load_i && stdp_w != w_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
      valid_q <= 1'b0;
      w_q     <= WEIGHT_W'(W_INIT);
    end else begin
      timer_q <= timer_d;
      valid_q <= valid_q | pre_spike_i;
      w_q     <= w_d;
    end
  end
  assign timer_o  = timer_q;
  assign weight_o = w_q;
endmodule

// File: rtl/stdp_array.sv
// stdp_array: pair-based STDP engine, NUM_PRE synapses onto one neuron.
// Optional STDP_WEIGHT_LOAD_EN adds a direct weight-load port.
module stdp_array
  import stdp_pkg::*;
#(
  parameter int NUM_PRE     = NUM_PRE_DEF,
  parameter int WEIGHT_W    = WEIGHT_W_DEF,
  parameter int TIMER_W     = TIMER_W_DEF,
  parameter int WINDOW      = WINDOW_DEF,
  parameter int A_PLUS      = A_PLUS_DEF,
  parameter int A_MINUS     = A_MINUS_DEF,
  parameter int DECAY_SHIFT = DECAY_SHIFT_DEF,
  parameter int W_INIT      = W_INIT_DEF,
  parameter int SEL_W       = (NUM_PRE > 1) ? $clog2(NUM_PRE) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         learn_en,
  input  logic [NUM_PRE-1:0]           pre_spike,
  input  logic                         post_spike,
  input  logic [SEL_W-1:0]             dbg_sel,
`ifdef STDP_WEIGHT_LOAD_EN
  input  logic                         wl_valid,
  input  logic [SEL_W-1:0]             wl_idx,
  input  logic [WEIGHT_W-1:0]          wl_data,
`endif
  output logic signed [TIMER_W:0]      time_diff,
  output logic                         update_w_flag,
  output logic [NUM_PRE*WEIGHT_W-1:0]  weight
);
  localparam int TMAX = 2**TIMER_W - 1;
  logic [TIMER_W-1:0] post_timer_q, post_timer_d, sel_timer;
  logic post_valid_q;
  logic [TIMER_W-1:0] pre_timer [NUM_PRE];
  logic [NUM_PRE-1:0] changed, load;
  logic [WEIGHT_W-1:0] load_data;
  logic signed [TIMER_W:0] td_q, td_d;
  logic flag_q;
`ifdef STDP_WEIGHT_LOAD_EN
  for (genvar g = 0; g < NUM_PRE; g++) begin : g_load
    assign load[g] = wl_valid && wl_idx == SEL_W'(g);
  end
  assign load_data = wl_data;
`else
  assign load      = '0;
  assign load_data = '0;
`endif
  for (genvar g = 0; g < NUM_PRE; g++) begin : g_ch
    stdp_syn_channel #(
      .WEIGHT_W(WEIGHT_W), .TIMER_W(TIMER_W), .WINDOW(WINDOW), .A_PLUS(A_PLUS),
      .A_MINUS(A_MINUS), .DECAY_SHIFT(DECAY_SHIFT), .W_INIT(W_INIT)
    ) u_ch (
      .clk(clk), .rst(rst), .learn_en_i(learn_en),
      .pre_spike_i(pre_spike[g]), .post_spike_i(post_spike),
      .post_valid_i(post_valid_q), .post_timer_i(post_timer_q),
      .load_i(load[g]), .load_data_i(load_data),
      .timer_o(pre_timer[g]),
      .weight_o(weight[(NUM_PRE-1-g)*WEIGHT_W +: WEIGHT_W]),
      .changed_o(changed[g])
    );
  end
  always_comb begin
    post_timer_d = TIMER_W'(timer_next(post_spike, int'(post_timer_q), TMAX));
    sel_timer    = int'(dbg_sel) < NUM_PRE ? pre_timer[dbg_sel] : '0;
    td_d         = $signed({1'b0, post_timer_q}) - $signed({1'b0, sel_timer});
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      post_timer_q <= '0;
      post_valid_q <= 1'b0;
      td_q         <= '0;
      flag_q       <= 1'b0;
    end else begin
      post_timer_q <= post_timer_d;
      post_valid_q <= post_valid_q | post_spike;
      td_q         <= td_d;
      flag_q       <= |changed;
    end
  end
  assign time_diff     = td_q;
  assign update_w_flag = flag_q;
endmodule

// File: tb/tb_stdp_array.sv
// tb_stdp_array: scoreboard bench; reference model tracks spike edge indices per channel.
module tb_stdp_array;
  localparam int NP = 4, WMAX = 255, TMAX = 63, WINDOW = 16, AP = 16, AM = 12, DS = 2, WI = 64;
  logic clk = 0, rst = 1, learn_en = 0, post_spike = 0;
  logic [3:0] pre_spike = '0;
  logic [1:0] dbg_sel = '0;
  logic signed [6:0] time_diff;
  logic update_w_flag;
  logic [31:0] weight;
`ifdef STDP_WEIGHT_LOAD_EN
  logic wl_valid = 0;
  logic [1:0] wl_idx = '0;
  logic [7:0] wl_data = '0;
`endif
  stdp_array dut (
    .clk(clk), .rst(rst), .learn_en(learn_en), .pre_spike(pre_spike),
    .post_spike(post_spike), .dbg_sel(dbg_sel),
`ifdef STDP_WEIGHT_LOAD_EN
    .wl_valid(wl_valid), .wl_idx(wl_idx), .wl_data(wl_data),
`endif
    .time_diff(time_diff), .update_w_flag(update_w_flag), .weight(weight)
  );
  always #5 clk = ~clk;
  typedef struct { logic [31:0] w; logic f; logic [6:0] td; } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  int n = 0, ev_post = 0;
  int w [NP], ev_pre [NP];
  bit v_pre [NP], v_post = 0;
  function automatic int tmr(input int ev);
    return (n - ev - 1 > TMAX) ? TMAX : n - ev - 1;
  endfunction
  task automatic step(input bit r, input bit le, input logic [3:0] pre, input bit post, input int sel);
    exp_t e;
    int pt, nw;
    int prt [NP];
    bit ch;
    @(negedge clk);
    rst = r; learn_en = le; pre_spike = pre; post_spike = post; dbg_sel = 2'(sel);
    if (r) begin
      for (int i = 0; i < NP; i++) begin w[i] = WI; ev_pre[i] = n; v_pre[i] = 0; end
      ev_post = n; v_post = 0; e.td = '0; e.f = 0;
    end else begin
      pt = tmr(ev_post);
      for (int i = 0; i < NP; i++) prt[i] = tmr(ev_pre[i]);
      e.td = 7'(pt - prt[sel]);
      ch = 0;
      for (int i = 0; i < NP; i++) begin
        nw = w[i];
        if (le && post && v_pre[i] && !pre[i] && prt[i] < WINDOW)
          nw = (w[i] + (AP >> (prt[i] >> DS)) > WMAX) ? WMAX : w[i] + (AP >> (prt[i] >> DS));
        else if (le && pre[i] && v_post && !post && pt < WINDOW)
          nw = (w[i] - (AM >> (pt >> DS)) < 0) ? 0 : w[i] - (AM >> (pt >> DS));
        if (nw != w[i]) ch = 1;
        w[i] = nw;
      end
      e.f = ch;
      for (int i = 0; i < NP; i++) if (pre[i]) begin ev_pre[i] = n; v_pre[i] = 1; end
      if (post) begin ev_post = n; v_post = 1; end
    end
    for (int i = 0; i < NP; i++) e.w[(NP-1-i)*8 +: 8] = 8'(w[i]);
    sb.push_back(e);
    n++;
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 1, 4'b0000, 0, int'($urandom_range(0, 3)));
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks += 3;
        if (weight !== e.w) begin errors++; $display("FAIL weight n=%0d got %h exp %h", n, weight, e.w); end
        if (update_w_flag !== e.f) begin errors++; $display("FAIL flag n=%0d got %b exp %b", n, update_w_flag, e.f); end
        if (time_diff !== e.td) begin errors++; $display("FAIL time_diff n=%0d got %0d exp %0d", n, time_diff, $signed(e.td)); end
      end
    end
  end
  initial begin
    logic [3:0] p;
    step(1, 1, 4'b0000, 0, 0);
    step(1, 1, 4'b0000, 0, 0);
    idle(2);
    step(0, 1, 4'b0001, 0, 0); idle(2); step(0, 1, 4'b0000, 1, 0); idle(3);
    step(0, 1, 4'b0000, 1, 1); idle(4); step(0, 1, 4'b0010, 0, 1); idle(3);
    step(0, 1, 4'b0100, 0, 2); idle(16); step(0, 1, 4'b0000, 1, 2); idle(20);
    repeat (14) begin step(0, 1, 4'b0001, 0, 0); idle(1); step(0, 1, 4'b0000, 1, 0); idle(20); end
    repeat (8) begin step(0, 1, 4'b0000, 1, 1); step(0, 1, 4'b0010, 0, 1); idle(20); end
    step(0, 1, 4'b1000, 1, 3); idle(2);
    step(0, 1, 4'b0001, 0, 0); idle(1); step(0, 0, 4'b0000, 1, 0); idle(20);
    step(0, 1, 4'b0001, 0, 0); idle(1); step(1, 1, 4'b0000, 0, 0); step(0, 1, 4'b0000, 1, 0); idle(3);
    repeat (3000) begin
      for (int i = 0; i < NP; i++) p[i] = ($urandom_range(0, 4) == 0);
      step($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0, p,
           $urandom_range(0, 4) == 0, int'($urandom_range(0, 3)));
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL drain left %0d exp 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
